// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, reset address and fetch state encoding
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_HOLD
  } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - fetch program counter with load, increment and reset value
module pc_register
  import cpu_pkg::*;
#(
  parameter int W = ADDR_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_rst_val,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  output logic [W-1:0] o_pc
);

  logic [W-1:0] r_pc;

  // A redirect load wins over the sequential increment; the increment wraps naturally
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc <= i_rst_val;
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else if (i_inc) begin
      r_pc <= r_pc + W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MERC-16 instruction fetch stage, one outstanding memory read
module fetch_unit #(
  parameter logic [cpu_pkg::ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic                       o_mem_req,
  output logic [cpu_pkg::ADDR_W-1:0] o_mem_addr,
  input  logic                       i_mem_ack,
  input  logic [cpu_pkg::DATA_W-1:0] i_mem_data,
  input  logic                       i_stall,
  input  logic                       i_br_taken,
  input  logic [cpu_pkg::ADDR_W-1:0] i_br_target,
  output logic                       o_ir_valid,
  input  logic                       i_ir_ready,
  output logic [cpu_pkg::DATA_W-1:0] o_ir,
  output logic [cpu_pkg::ADDR_W-1:0] o_ir_pc
);

  import cpu_pkg::*;

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic              r_kill;
  logic              w_kill_nxt;
  logic              r_mem_req;
  logic              w_mem_req_nxt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic              r_ir_valid;
  logic              w_ir_valid_nxt;
  logic [DATA_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_ir_pc;
  logic              w_capture;
  logic              w_pc_inc;
  logic [ADDR_W-1:0] w_fetch_pc;
  logic [ADDR_W-1:0] w_issue_pc;

  // A redirect in the same cycle as an issue decision must be the address issued
  assign w_issue_pc = i_br_taken ? i_br_target : w_fetch_pc;

  pc_register #(
    .W(ADDR_W)
  ) u_pc (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rst_val  (RESET_PC),
    .i_load     (i_br_taken),
    .i_load_val (i_br_target),
    .i_inc      (w_pc_inc),
    .o_pc       (w_fetch_pc)
  );

  // Next-state and next-output decisions; every register holds unless a state acts
  always_comb begin
    w_state_nxt    = r_state;
    w_kill_nxt     = r_kill;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_ir_valid_nxt = r_ir_valid;
    w_capture      = 1'b0;
    w_pc_inc       = 1'b0;
    case (r_state)
      FETCH_IDLE: begin
        w_mem_req_nxt = 1'b0;
        if (!i_stall) begin
          w_state_nxt    = FETCH_REQ;
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = w_issue_pc;
        end
      end
      FETCH_REQ: begin
        if (i_mem_ack) begin
          if (r_kill || i_br_taken) begin
            // stale data from before a redirect is dropped and the target refetched
            w_kill_nxt = 1'b0;
            if (!i_stall) begin
              w_mem_addr_nxt = w_issue_pc;
            end else begin
              w_state_nxt   = FETCH_IDLE;
              w_mem_req_nxt = 1'b0;
            end
          end else begin
            w_capture      = 1'b1;
            w_pc_inc       = 1'b1;
            w_ir_valid_nxt = 1'b1;
            w_mem_req_nxt  = 1'b0;
            w_state_nxt    = FETCH_HOLD;
          end
        end else if (i_br_taken) begin
          // the request cannot be withdrawn, so remember to discard its data
          w_kill_nxt = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (i_br_taken || i_ir_ready) begin
          w_ir_valid_nxt = 1'b0;
          if (!i_stall) begin
            w_state_nxt    = FETCH_REQ;
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = w_issue_pc;
          end else begin
            w_state_nxt = FETCH_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt   = FETCH_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  // Control and memory-side output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= FETCH_IDLE;
      r_kill     <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_kill     <= w_kill_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_ir_valid <= w_ir_valid_nxt;
    end
  end

  // Instruction and its address are captured together and kept after consumption
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ir    <= '0;
      r_ir_pc <= '0;
    end else if (w_capture) begin
      r_ir    <= i_mem_data;
      r_ir_pc <= w_fetch_pc;
    end
  end

  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;
  assign o_ir_valid = r_ir_valid;
  assign o_ir       = r_ir;
  assign o_ir_pc    = r_ir_pc;

endmodule
